// File: rtl/decision_pkg.sv
// decision_pkg: shared FSM and selection-mode encodings for the decision engine
package decision_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        MODE_FIRST_FREE = 1'b0,
        MODE_MAX_ACT    = 1'b1
    } mode_e;

endpackage

// File: rtl/activity_bank.sv
// activity_bank: per-variable activity counters with saturating bump, rescale and decay
module activity_bank
    import decision_pkg::*;
#(
    parameter int NUM_VARS  = 16,
    parameter int ACT_WIDTH = 8,
    parameter int LANES     = 4,
    localparam int VAR_W    = $clog2(NUM_VARS + 1),
    localparam int S        = NUM_VARS / LANES,
    localparam int CI       = S > 1 ? $clog2(S) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            bump_valid,
    input  logic [VAR_W-1:0]                bump_var,
    input  logic                            decay,
    input  logic [CI-1:0]                   chunk,
    output logic [LANES-1:0][ACT_WIDTH-1:0] lane_act
);

    logic [S-1:0][LANES-1:0][ACT_WIDTH-1:0] act_q, act_d;
    logic                                   sat;

    assign lane_act = act_q[chunk];

    // Halve everything on decay or on a bump of a saturated counter (never twice), then apply the bump
    always_comb begin
        sat = 1'b0;
        for (int c = 0; c < S; c++)
            for (int l = 0; l < LANES; l++)
                sat = sat | (bump_valid && bump_var == VAR_W'(c * LANES + l + 1) && act_q[c][l] == '1);
        for (int c = 0; c < S; c++)
            for (int l = 0; l < LANES; l++) begin
                act_d[c][l] = (decay || sat) ? act_q[c][l] >> 1 : act_q[c][l];
                if (bump_valid && bump_var == VAR_W'(c * LANES + l + 1) && act_d[c][l] != '1)
                    act_d[c][l] = act_d[c][l] + 1'b1;
            end
    end

    // Counter storage
    always_ff @(posedge clk) begin
        if (!rst_n)
            act_q <= '0;
        else
            act_q <= act_d;
    end

endmodule

// File: rtl/decision_engine.sv
// decision_engine: scanning branching-variable selector with activity and saved-phase tracking
module decision_engine
    import decision_pkg::*;
#(
    parameter int NUM_VARS  = 16,
    parameter int ACT_WIDTH = 8,
    parameter int LANES     = 4,
    localparam int VAR_W    = $clog2(NUM_VARS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [NUM_VARS:1]  assigned,
    input  logic               req_valid,
    output logic               req_ready,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [VAR_W-1:0]   dec_var,
    output logic               dec_pol,
    output logic               dec_none,
    input  logic               bump_valid,
    input  logic [VAR_W-1:0]   bump_var,
    input  logic               decay,
    input  logic               phase_valid,
    input  logic [VAR_W-1:0]   phase_var,
    input  logic               phase_val
);

    localparam int S  = NUM_VARS / LANES;
    localparam int CI = S > 1 ? $clog2(S) : 1;
    localparam int CW = $clog2(S + 1);

    state_e                          state_q, state_d;
    mode_e                           mode_q, mode_d;
    logic [CW-1:0]                   chunk_q, chunk_d;
    logic [VAR_W-1:0]                best_var_q, best_var_d, lw_var_q, lw_var_d, win_var;
    logic [ACT_WIDTH-1:0]            best_act_q, best_act_d, lw_act_q, lw_act_d, win_act;
    logic                            pol_q, pol_d;
    logic [NUM_VARS:1]               phase_q, phase_d;
    logic [NUM_VARS:0]               phase_ext;
    logic [S-1:0][LANES-1:0]         asg_c;
    logic [LANES-1:0][ACT_WIDTH-1:0] lane_act;
    logic [CI-1:0]                   ci;

    assign asg_c     = assigned;
    assign ci        = chunk_q[CI-1:0];
    assign phase_ext = {phase_q, 1'b0};

    assign req_ready = state_q == IDLE;
    assign dec_valid = state_q == DONE;
    assign dec_var   = dec_valid ? best_var_q : '0;
    assign dec_none  = dec_valid && best_var_q == '0;
    assign dec_pol   = dec_valid && pol_q;

    activity_bank #(
        .NUM_VARS (NUM_VARS),
        .ACT_WIDTH(ACT_WIDTH),
        .LANES    (LANES)
    ) u_act (
        .clk       (clk),
        .rst_n     (rst_n),
        .bump_valid(bump_valid),
        .bump_var  (bump_var),
        .decay     (decay),
        .chunk     (ci),
        .lane_act  (lane_act)
    );

    // Lane winner of the current chunk; ascending lane order gives ties to the lower index
    always_comb begin
        win_var = '0;
        win_act = '0;
        for (int l = 0; l < LANES; l++)
            if (!asg_c[ci][l] && (win_var == '0 || (mode_q == MODE_MAX_ACT && lane_act[l] > win_act))) begin
                win_var = VAR_W'(int'(ci) * LANES + l + 1);
                win_act = lane_act[l];
            end
    end

    // FSM: lane winner is registered one cycle, then merged into the best candidate
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        chunk_d    = chunk_q;
        best_var_d = best_var_q;
        best_act_d = best_act_q;
        lw_var_d   = lw_var_q;
        lw_act_d   = lw_act_q;
        pol_d      = pol_q;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d    = SCAN;
                mode_d     = mode_e'(mode);
                chunk_d    = '0;
                best_var_d = '0;
                best_act_d = '0;
                lw_var_d   = '0;
                lw_act_d   = '0;
            end
            SCAN: begin
                if (lw_var_q != '0 && (best_var_q == '0 || (mode_q == MODE_MAX_ACT && lw_act_q > best_act_q))) begin
                    best_var_d = lw_var_q;
                    best_act_d = lw_act_q;
                end
                lw_var_d = win_var;
                lw_act_d = win_act;
                chunk_d  = chunk_q + 1'b1;
                if (chunk_q == CW'(S)) begin
                    state_d = DONE;
                    pol_d   = phase_ext[best_var_d];
                end
            end
            DONE: if (dec_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Saved-phase writes; out-of-range indices match nothing
    always_comb begin
        phase_d = phase_q;
        for (int v = 1; v <= NUM_VARS; v++)
            if (phase_valid && phase_var == VAR_W'(v))
                phase_d[v] = phase_val;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= MODE_FIRST_FREE;
            chunk_q    <= '0;
            best_var_q <= '0;
            best_act_q <= '0;
            lw_var_q   <= '0;
            lw_act_q   <= '0;
            pol_q      <= 1'b0;
            phase_q    <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            chunk_q    <= chunk_d;
            best_var_q <= best_var_d;
            best_act_q <= best_act_d;
            lw_var_q   <= lw_var_d;
            lw_act_q   <= lw_act_d;
            pol_q      <= pol_d;
            phase_q    <= phase_d;
        end
    end

endmodule

// File: tb/tb_decision_engine.sv
// tb_decision_engine: directed table-driven bench for decision_engine
module tb_decision_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0;
    logic [16:1] assigned = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [4:0]  dec_var;
    logic        dec_pol;
    logic        dec_none;
    logic        bump_valid = 1'b0;
    logic [4:0]  bump_var = '0;
    logic        decay = 1'b0;
    logic        phase_valid = 1'b0;
    logic [4:0]  phase_var = '0;
    logic        phase_val = 1'b0;

    int checks = 0;
    int errors = 0;

    decision_engine dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .assigned(assigned),
        .req_valid(req_valid), .req_ready(req_ready),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_var(dec_var), .dec_pol(dec_pol), .dec_none(dec_none),
        .bump_valid(bump_valid), .bump_var(bump_var), .decay(decay),
        .phase_valid(phase_valid), .phase_var(phase_var), .phase_val(phase_val)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct packed {
        logic        m;
        logic [15:0] a;
        logic [4:0]  ev;
        logic        ep;
        logic        en;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input int act, input int exp, input string nm);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // All tasks start and end just after a falling edge
    task automatic bump(input int v, input int n);
        repeat (n) begin
            bump_valid = 1'b1;
            bump_var   = 5'(v);
            @(negedge clk);
        end
        bump_valid = 1'b0;
    endtask

    task automatic set_phase(input int v, input logic val);
        phase_valid = 1'b1;
        phase_var   = 5'(v);
        phase_val   = val;
        @(negedge clk);
        phase_valid = 1'b0;
    endtask

    task automatic start_req(input logic m, input logic [16:1] a, input string nm);
        chk(req_ready, 1, {nm, " req_ready"});
        mode      = m;
        assigned  = a;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_dec(input string nm);
        int n = 0;
        while (!dec_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(n, 5, {nm, " latency"});
    endtask

    task automatic finish_dec(input string nm);
        dec_ready = 1'b1;
        @(negedge clk);
        dec_ready = 1'b0;
        chk(dec_valid, 0, {nm, " valid after handshake"});
        chk(req_ready, 1, {nm, " ready after handshake"});
    endtask

    task automatic run_req(input logic m, input logic [16:1] a, input int ev, input logic ep,
                           input logic en, input string nm);
        start_req(m, a, nm);
        wait_dec(nm);
        chk(dec_var, ev, {nm, " dec_var"});
        chk(dec_pol, ep, {nm, " dec_pol"});
        chk(dec_none, en, {nm, " dec_none"});
        finish_dec(nm);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 16'h0007, 5'd4,  1'b0, 1'b0};
        tbl[1]  = '{1'b0, 16'hFFFF, 5'd0,  1'b0, 1'b1};
        tbl[2]  = '{1'b1, 16'hFFFF, 5'd0,  1'b0, 1'b1};
        tbl[3]  = '{1'b1, 16'h0000, 5'd1,  1'b0, 1'b0};
        tbl[4]  = '{1'b1, 16'h0000, 5'd9,  1'b0, 1'b0};
        tbl[5]  = '{1'b1, 16'h0100, 5'd12, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 16'h0100, 5'd1,  1'b0, 1'b0};
        tbl[7]  = '{1'b0, 16'hFFBF, 5'd7,  1'b1, 1'b0};
        tbl[8]  = '{1'b1, 16'hFFBF, 5'd7,  1'b1, 1'b0};
        tbl[9]  = '{1'b1, 16'h0FFF, 5'd13, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 16'h0010, 5'd9,  1'b0, 1'b0};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk(req_ready, 1, "reset req_ready");
        chk(dec_valid, 0, "reset dec_valid");
        chk(dec_var, 0, "reset dec_var");
        chk(dec_pol, 0, "reset dec_pol");
        chk(dec_none, 0, "reset dec_none");

        for (int i = 0; i < 11; i++) begin
            if (i == 4) begin
                bump(9, 3);
                bump(12, 3);
                bump(5, 1);
                bump(0, 5);
                bump(17, 5);
                set_phase(7, 1'b1);
            end
            run_req(tbl[i].m, tbl[i].a, int'(tbl[i].ev), tbl[i].ep, tbl[i].en, $sformatf("vec%0d", i));
        end

        start_req(1'b0, 16'hFFBF, "hold");
        wait_dec("hold");
        for (int c = 0; c < 3; c++) begin
            chk(dec_valid, 1, "hold dec_valid");
            chk(dec_var, 7, "hold dec_var");
            chk(dec_pol, 1, "hold dec_pol");
            chk(req_ready, 0, "hold req_ready");
            @(negedge clk);
        end
        finish_dec("hold");

        start_req(1'b0, 16'hFFBF, "late_phase");
        repeat (4) @(negedge clk);
        chk(dec_valid, 0, "late_phase early valid");
        set_phase(7, 1'b0);
        chk(dec_valid, 1, "late_phase valid");
        chk(dec_pol, 1, "late_phase dec_pol");
        finish_dec("late_phase");
        run_req(1'b0, 16'hFFBF, 7, 1'b0, 1'b0, "phase_cleared");

        bump(2, 255);
        bump(3, 2);
        run_req(1'b1, 16'h0000, 2, 1'b0, 1'b0, "sat_255");
        bump(2, 1);
        bump(4, 128);
        run_req(1'b1, 16'h0000, 2, 1'b0, 1'b0, "rescale_tie");
        bump(4, 1);
        run_req(1'b1, 16'h0000, 4, 1'b0, 1'b0, "rescale_129");
        decay = 1'b1;
        bump(3, 1);
        decay = 1'b0;
        run_req(1'b1, 16'h000A, 3, 1'b0, 1'b0, "decay_bump");
        run_req(1'b1, 16'h0000, 2, 1'b0, 1'b0, "decay_halved");
        bump(4, 191);
        decay = 1'b1;
        bump(4, 1);
        decay = 1'b0;
        bump(6, 128);
        run_req(1'b1, 16'h0000, 4, 1'b0, 1'b0, "single_halve_tie");
        bump(6, 1);
        run_req(1'b1, 16'h0000, 6, 1'b0, 1'b0, "single_halve_gt");

        start_req(1'b1, 16'h0000, "mid_reset");
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk(req_ready, 1, "mid_reset req_ready");
        chk(dec_valid, 0, "mid_reset dec_valid");
        begin
            int seen = 0;
            repeat (8) begin
                @(negedge clk);
                if (dec_valid) seen++;
            end
            chk(seen, 0, "mid_reset no dec_valid");
        end
        run_req(1'b1, 16'h0000, 1, 1'b0, 1'b0, "post_reset_act");
        run_req(1'b0, 16'hFFBF, 7, 1'b0, 1'b0, "post_reset_phase");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decision_engine.md
# decision_engine

Sequential, parametrised branching-variable selector for the DPLL/CDCL core. Replaces the purely combinational lowest-free-index picker. It keeps per-variable activity counters, which are bumped by conflict analysis and periodically decayed, and per-variable saved phases. On request it scans the assignment vector LANES variables per cycle and returns the chosen free variable and its polarity over a valid/ready handshake. Mode selects first-free or max-activity selection.

## Interface
- NUM_VARS, 16: number of variables; indices 1..NUM_VARS, index 0 means "none".
- ACT_WIDTH, 8: activity counter width.
- LANES, 4: variables examined per scan cycle; must divide NUM_VARS.
- VAR_W (localparam) = $clog2(NUM_VARS+1); S (localparam) = NUM_VARS/LANES scan cycles.
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- mode  in  1  0 = first-free, 1 = max-activity; sampled when a request is accepted.
- assigned  in  [NUM_VARS:1]  1 = variable currently assigned; must be held stable from request acceptance until dec_valid.
- req_valid  in  1  decision request.
- req_ready  out  1  high only in IDLE.
- dec_valid  out  1  result valid; held until dec_ready.
- dec_ready  in  1  consumer accepts the result.
- dec_var  out  VAR_W  chosen variable; 0 when dec_none.
- dec_pol  out  1  saved phase of dec_var; 0 when dec_none.
- dec_none  out  1  every variable is assigned.
- bump_valid, bump_var  in  1, VAR_W  increment the activity of bump_var.
- decay  in  1  halve all activity counters.
- phase_valid, phase_var, phase_val  in  1, VAR_W, 1  write the saved phase of phase_var.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE -> SCAN on req_valid && req_ready. Latch mode; clear the best-candidate register (best_var = 0, best_act = 0).
- SCAN: chunk c (c = 0..S-1) covers variables c·LANES+1 .. (c+1)·LANES. Among the free variables in the chunk, pick the lane winner, then merge it with the best-candidate register.
  - Mode 0: keep the first free variable found.
  - Mode 1: replace the best only on strictly greater activity, so ties go to the lower index. A free variable with activity 0 still beats best_var = 0.
- The scan always runs all S cycles; no early exit, so latency is fixed. Go to DONE after chunk S-1.
- DONE: dec_valid = 1. dec_var = best_var. dec_none = (best_var == 0). dec_pol = saved phase of best_var, sampled on entry to DONE.
- DONE -> IDLE on dec_ready. Outputs stay stable while dec_ready is low.
- Activity bump: saturating increment.
  - If the bumped counter is at 2^ACT_WIDTH-1, all counters are halved (logical shift right by 1) and then the bumped counter is incremented, all in the same cycle.
- decay: all counters shift right by 1.
  - decay together with bump: halve first, then increment the bumped counter.
  - decay together with a saturated bump: exactly one halving.
- Bump, decay and phase writes are accepted in every state. During SCAN, each chunk compares the counter values present in that cycle.
- A bump_var or phase_var of 0 or greater than NUM_VARS is ignored.
- Phase write: saved[phase_var] <= phase_val. Writes take effect the following cycle.

## Timing
- Reset values: state = IDLE; req_ready = 1 in the first cycle after reset deassertion; dec_valid = 0; dec_var = 0; dec_pol = 0; dec_none = 0; all activity counters = 0; all saved phases = 0.
- Latency: request accepted at edge k; dec_valid is high after edge k+S+1, i.e. S+1 cycles (5 for the defaults).
- Throughput: DONE handshake at edge m puts the FSM in IDLE; the next request can be accepted at edge m+1.
- Reset mid-scan or mid-DONE: the FSM aborts to IDLE in the same edge; no dec_valid is produced and counters/phases are cleared.
- A phase write to the chosen variable in the same cycle as the SCAN->DONE transition is not reflected in dec_pol.

## Structure
- Package decision_pkg: state enum (IDLE, SCAN, DONE) and mode enum (MODE_FIRST_FREE = 0, MODE_MAX_ACT = 1).
- Sub-module activity_bank: counter array with bump/saturate-rescale/decay. It exposes the LANES activity values for a chunk index (combinational read).
- Top level holds the FSM, chunk counter, best-candidate register, phase array and lane comparator.

## Test plan
- Mode 0, defaults, assigned[1..3] = 1 and the rest 0 -> dec_var = 4, dec_pol = 0, dec_none = 0; dec_valid exactly 5 cycles after acceptance.
- Mode 1: bump var 9 ×3, var 12 ×3, var 5 ×1, all free -> dec_var = 9 (lowest index wins the tie). Then set assigned[9] = 1 and request again -> dec_var = 12.
- Saturation: bump var 2 ×255 -> activity 255; bump var 3 ×2 -> 2; bump var 2 once more -> var 2 = 128, var 3 = 1. Simultaneous decay + bump of var 3 (activity 1) -> var 3 = 1, var 2 = 64.
- All 16 variables assigned, either mode -> dec_none = 1, dec_var = 0, dec_pol = 0.
- phase_valid for var 7 with phase_val = 1, only var 7 free -> dec_pol = 1. Holding dec_ready low for 3 cycles keeps dec_valid/dec_var/dec_pol stable; req_ready stays 0 until the handshake.
- rst_n low during the 2nd scan cycle -> dec_valid never asserts; req_ready = 1 the cycle after release; a fresh request in mode 1 with no bumps -> dec_var = 1.
